// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequential unsigned WIDTH x WIDTH shift-and-add multiplier with start/ready/done handshake
module shift_add_mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]         state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  always_comb acc_nxt = mplier[0] ? acc + mcand : acc;
  assign ready = state == IDLE;
  assign busy  = state == RUN || state == DONE;
  assign done  = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
        state  <= RUN;
      end
    end else if (state == RUN) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == CNT_W'(WIDTH - 1)) begin
        product <= acc_nxt;
        state   <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb_shift_add_mult_ctrl: directed self-checking bench for shift_add_mult_ctrl
module tb_shift_add_mult_ctrl;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready, busy, done;
  logic [63:0] product;
  int checks = 0;
  int failures = 0;
  shift_add_mult_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .product(product)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [31:0] xa, input logic [31:0] xb, input bit inj,
                       output int lat, output logic [63:0] mid);
    @(negedge clk);
    a = xa;
    b = xb;
    start = 1;
    @(negedge clk);
    start = 0;
    a = '0;
    b = '0;
    lat = 1;
    mid = 'x;
    while (!done && lat < 100) begin
      if (lat == 16) mid = product;
      if (inj && lat == 10) begin
        start = 1;
        a = 7;
        b = 7;
      end else start = 0;
      @(negedge clk);
      lat++;
    end
    start = 0;
    chk("op_timeout", 64'(lat < 100), 64'd1);
  endtask
  int lat, cnt_done, gap;
  logic [63:0] mid;
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", product, 64'd0);
    do_op(32'd3, 32'd5, 0, lat, mid);
    chk("lat_3x5", 64'(lat), 64'd33);
    chk("prod_3x5", product, 64'hF);
    chk("done_busy", 64'(busy), 64'd1);
    chk("done_ready", 64'(ready), 64'd0);
    @(negedge clk);
    chk("post_ready", 64'(ready), 64'd1);
    chk("post_done", 64'(done), 64'd0);
    chk("post_hold", product, 64'hF);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, mid);
    chk("prod_max", product, 64'hFFFFFFFE00000001);
    do_op(32'h80000000, 32'h2, 0, lat, mid);
    chk("prod_msb", product, 64'h0000000100000000);
    do_op(32'h0, 32'h12345678, 0, lat, mid);
    chk("mid_hold", mid, 64'h0000000100000000);
    chk("lat_zero", 64'(lat), 64'd33);
    chk("prod_zero", product, 64'd0);
    do_op(32'd11, 32'd13, 1, lat, mid);
    chk("lat_inj", 64'(lat), 64'd33);
    chk("prod_inj", product, 64'd143);
    cnt_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    chk("inj_extra_done", 64'(cnt_done), 64'd0);
    @(negedge clk);
    a = 5;
    b = 5;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (19) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mrst_ready", 64'(ready), 64'd1);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_product", product, 64'd0);
    cnt_done = 0;
    repeat (40) begin
      if (done) cnt_done++;
      @(negedge clk);
    end
    chk("mrst_no_done", 64'(cnt_done), 64'd0);
    do_op(32'd2, 32'd9, 0, lat, mid);
    chk("lat_2x9", 64'(lat), 64'd33);
    chk("prod_2x9", product, 64'd18);
    @(negedge clk);
    a = 6;
    b = 7;
    start = 1;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("held1_timeout", 64'(lat < 100), 64'd1);
    chk("held1_prod", product, 64'd42);
    chk("held1_ready", 64'(ready), 64'd0);
    a = 10;
    b = 10;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!done && gap < 100);
    start = 0;
    chk("held_gap", 64'(gap), 64'd34);
    chk("held2_prod", product, 64'd100);
    @(negedge clk);
    chk("end_ready", 64'(ready), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
